up_regmap_responder: RTL and testbench

UP_REGMAP_RESPONDER -- requirements
Module: up_regmap_responder

---
 rtl/up_regmap_responder.sv | 115 +++++++++++
 tb/tb_up_regmap_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/up_regmap_responder.sv
// Register-map responder for the up_* request/ack bus: identity, scratch, control,
// W1C interrupt pending with mask, and a set-by-software / cleared-by-hardware trigger.
module up_regmap_responder #(
    parameter int unsigned ID           = 0,
    parameter logic [31:0] CORE_VERSION = 32'h0001_0061
) (
    input  logic        up_clk,
    input  logic        up_rstn,
    input  logic        up_wreq,
    input  logic [13:0] up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    input  logic        up_rreq,
    input  logic [13:0] up_raddr,
    output logic [31:0] up_rdata,
    output logic        up_rack,
    input  logic [7:0]  irq_event,
    input  logic [7:0]  trigger_done,
    output logic        ctrl_enable,
    output logic [3:0]  ctrl_mode,
    output logic [7:0]  trigger_req,
    output logic        irq
);

    localparam logic [13:0] ADDR_VERSION = 14'h0000;
    localparam logic [13:0] ADDR_ID      = 14'h0001;
    localparam logic [13:0] ADDR_SCRATCH = 14'h0002;
    localparam logic [13:0] ADDR_CONTROL = 14'h0010;
    localparam logic [13:0] ADDR_PENDING = 14'h0011;
    localparam logic [13:0] ADDR_MASK    = 14'h0012;
    localparam logic [13:0] ADDR_TRIGGER = 14'h0013;

    logic        wack_q;
    logic        rack_q,    rack_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic        enable_q,  enable_d;
    logic [3:0]  mode_q,    mode_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q,    mask_d;
    logic [7:0]  trigger_q, trigger_d;
    logic        irq_q,     irq_d;

    logic wr_scratch, wr_control, wr_pending, wr_mask, wr_trigger;

    assign wr_scratch = up_wreq && (up_waddr == ADDR_SCRATCH);
    assign wr_control = up_wreq && (up_waddr == ADDR_CONTROL);
    assign wr_pending = up_wreq && (up_waddr == ADDR_PENDING);
    assign wr_mask    = up_wreq && (up_waddr == ADDR_MASK);
    assign wr_trigger = up_wreq && (up_waddr == ADDR_TRIGGER);

    // Read mux samples current register state, so a coincident write is not visible.
    always_comb begin
        rack_d  = up_rreq;
        rdata_d = 32'h0;
        if (up_rreq) begin
            case (up_raddr)
                ADDR_VERSION: rdata_d = CORE_VERSION;
                ADDR_ID:      rdata_d = 32'(ID);
                ADDR_SCRATCH: rdata_d = scratch_q;
                ADDR_CONTROL: rdata_d = {24'h0, mode_q, 3'b000, enable_q};
                ADDR_PENDING: rdata_d = {24'h0, pending_q};
                ADDR_MASK:    rdata_d = {24'h0, mask_q};
                ADDR_TRIGGER: rdata_d = {24'h0, trigger_q};
                default:      rdata_d = 32'h0;
            endcase
        end
    end

    // Set sources win over clears in both the pending and trigger registers.
    always_comb begin
        scratch_d = wr_scratch ? up_wdata : scratch_q;
        enable_d  = wr_control ? up_wdata[0]   : enable_q;
        mode_d    = wr_control ? up_wdata[7:4] : mode_q;
        mask_d    = wr_mask    ? up_wdata[7:0] : mask_q;
        pending_d = (pending_q & ~(wr_pending ? up_wdata[7:0] : 8'h00)) | irq_event;
        trigger_d = (trigger_q & ~trigger_done) | (wr_trigger ? up_wdata[7:0] : 8'h00);
        irq_d     = |(pending_q & ~mask_q);
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wack_q    <= 1'b0;
            rack_q    <= 1'b0;
            rdata_q   <= 32'h0;
            scratch_q <= 32'h0;
            enable_q  <= 1'b0;
            mode_q    <= 4'h0;
            pending_q <= 8'h00;
            mask_q    <= 8'hFF;
            trigger_q <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            wack_q    <= up_wreq;
            rack_q    <= rack_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            trigger_q <= trigger_d;
            irq_q     <= irq_d;
        end
    end

    assign up_wack     = wack_q;
    assign up_rack     = rack_q;
    assign up_rdata    = rdata_q;
    assign ctrl_enable = enable_q;
    assign ctrl_mode   = mode_q;
    assign trigger_req = trigger_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_up_regmap_responder.sv
// Directed bench for up_regmap_responder: hand-computed register values checked with
// immediate assertions after each clock edge.
module tb_up_regmap_responder;

    localparam int unsigned TB_ID = 32'h0000_005A;

    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        up_wreq = 1'b0;
    logic [13:0] up_waddr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_wack;
    logic        up_rreq = 1'b0;
    logic [13:0] up_raddr = '0;
    logic [31:0] up_rdata;
    logic        up_rack;
    logic [7:0]  irq_event = '0;
    logic [7:0]  trigger_done = '0;
    logic        ctrl_enable;
    logic [3:0]  ctrl_mode;
    logic [7:0]  trigger_req;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    up_regmap_responder #(.ID(TB_ID)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .irq_event(irq_event), .trigger_done(trigger_done),
        .ctrl_enable(ctrl_enable), .ctrl_mode(ctrl_mode), .trigger_req(trigger_req),
        .irq(irq)
    );

    always #5 up_clk = ~up_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [13:0] addr, input logic [31:0] exp);
        up_rreq = 1'b1;
        up_raddr = addr;
        tick();
        up_rreq = 1'b0;
        check({tag, "_rack"}, 32'(up_rack), 32'd1);
        check({tag, "_rdata"}, up_rdata, exp);
        tick();
        check({tag, "_rack_low"}, 32'(up_rack), 32'd0);
        check({tag, "_rdata_low"}, up_rdata, 32'h0);
    endtask

    task automatic do_write(input string tag, input logic [13:0] addr, input logic [31:0] data);
        up_wreq = 1'b1;
        up_waddr = addr;
        up_wdata = data;
        tick();
        up_wreq = 1'b0;
        check({tag, "_wack"}, 32'(up_wack), 32'd1);
        tick();
        check({tag, "_wack_low"}, 32'(up_wack), 32'd0);
    endtask

    initial begin
        // Requests and events during reset must be ignored.
        up_wreq = 1'b1; up_waddr = 14'h0002; up_wdata = 32'h1111_1111;
        up_rreq = 1'b1; up_raddr = 14'h0000;
        irq_event = 8'hFF; trigger_done = 8'hFF;
        tick(); tick();
        check("rst_wack", 32'(up_wack), 32'd0);
        check("rst_rack", 32'(up_rack), 32'd0);
        check("rst_rdata", up_rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_trig", 32'(trigger_req), 32'h0);
        check("rst_ctrl", {27'h0, ctrl_mode, ctrl_enable}, 32'h0);
        up_wreq = 1'b0; up_rreq = 1'b0; irq_event = 8'h00; trigger_done = 8'h00;
        #2 up_rstn = 1'b1;
        tick();
        check("post_rst_wack", 32'(up_wack), 32'd0);

        do_read("rd_version", 14'h0000, 32'h0001_0061);
        do_read("rd_id", 14'h0001, 32'h0000_005A);
        do_read("rd_mask_rst", 14'h0012, 32'h0000_00FF);
        do_read("rd_pend_rst", 14'h0011, 32'h0);
        do_read("rd_scratch_rst", 14'h0002, 32'h0);

        do_write("wr_scratch", 14'h0002, 32'hDEAD_BEEF);
        do_read("rd_scratch", 14'h0002, 32'hDEAD_BEEF);
        do_write("wr_ctrl", 14'h0010, 32'hFFFF_FFFF);
        check("ctrl_enable", 32'(ctrl_enable), 32'd1);
        check("ctrl_mode", 32'(ctrl_mode), 32'hF);
        do_read("rd_ctrl", 14'h0010, 32'h0000_00F1);
        do_write("wr_ctrl2", 14'h0010, 32'h0000_0050);
        check("ctrl_enable2", 32'(ctrl_enable), 32'd0);
        check("ctrl_mode2", 32'(ctrl_mode), 32'h5);

        // Interrupts
        do_write("wr_mask", 14'h0012, 32'h0000_00FE);
        check("irq_masked_idle", 32'(irq), 32'd0);
        irq_event = 8'h05;
        tick();
        irq_event = 8'h00;
        check("irq_one_cycle", 32'(irq), 32'd0);
        tick();
        check("irq_two_cycles", 32'(irq), 32'd1);
        do_read("rd_pend", 14'h0011, 32'h0000_0005);
        do_write("clr_pend0", 14'h0011, 32'h0000_0001);
        check("irq_cleared", 32'(irq), 32'd0);
        do_read("rd_pend2", 14'h0011, 32'h0000_0004);
        up_wreq = 1'b1; up_waddr = 14'h0011; up_wdata = 32'h0000_0004; irq_event = 8'h04;
        tick();
        up_wreq = 1'b0; irq_event = 8'h00;
        check("pend_race_wack", 32'(up_wack), 32'd1);
        tick();
        do_read("rd_pend_race", 14'h0011, 32'h0000_0004);
        do_write("clr_pend2", 14'h0011, 32'h0000_0004);
        do_read("rd_pend_clr", 14'h0011, 32'h0);

        // Trigger
        do_write("wr_trig", 14'h0013, 32'h0000_0003);
        check("trig_set", 32'(trigger_req), 32'h03);
        trigger_done = 8'h01;
        tick();
        trigger_done = 8'h00;
        check("trig_done0", 32'(trigger_req), 32'h02);
        up_wreq = 1'b1; up_waddr = 14'h0013; up_wdata = 32'h0000_0002; trigger_done = 8'h02;
        tick();
        up_wreq = 1'b0; trigger_done = 8'h00;
        check("trig_race_wack", 32'(up_wack), 32'd1);
        check("trig_race", 32'(trigger_req), 32'h02);
        tick();
        do_write("wr_trig_zero", 14'h0013, 32'h0);
        check("trig_zero_noeffect", 32'(trigger_req), 32'h02);
        do_read("rd_trig", 14'h0013, 32'h0000_0002);

        // Unmapped and read-only
        do_read("rd_unmapped", 14'h3FFF, 32'h0);
        do_write("wr_unmapped", 14'h3FFF, 32'h0000_0001);
        do_write("wr_version", 14'h0000, 32'h0);
        do_read("rd_version2", 14'h0000, 32'h0001_0061);
        do_read("rd_scratch_kept", 14'h0002, 32'hDEAD_BEEF);
        do_read("rd_mask_kept", 14'h0012, 32'h0000_00FE);

        // Coincident read and write of SCRATCH returns the old value
        up_wreq = 1'b1; up_waddr = 14'h0002; up_wdata = 32'h1234_5678;
        up_rreq = 1'b1; up_raddr = 14'h0002;
        tick();
        up_wreq = 1'b0; up_rreq = 1'b0;
        check("rw_same_rack", 32'(up_rack), 32'd1);
        check("rw_same_wack", 32'(up_wack), 32'd1);
        check("rw_same_old", up_rdata, 32'hDEAD_BEEF);
        tick();
        do_read("rd_scratch_new", 14'h0002, 32'h1234_5678);

        // Back-to-back reads
        up_rreq = 1'b1; up_raddr = 14'h0000;
        tick();
        up_raddr = 14'h0001;
        check("b2b_rd0", up_rdata, 32'h0001_0061);
        tick();
        up_rreq = 1'b0;
        check("b2b_rd1_rack", 32'(up_rack), 32'd1);
        check("b2b_rd1", up_rdata, 32'h0000_005A);
        tick();
        check("b2b_idle", 32'(up_rack), 32'd0);

        // Raise irq, then reset mid-write: no ack afterwards, state back to reset values
        irq_event = 8'h01;
        tick();
        irq_event = 8'h00;
        tick();
        check("irq_before_rst", 32'(irq), 32'd1);
        up_wreq = 1'b1; up_waddr = 14'h0002; up_wdata = 32'hCAFE_F00D;
        tick();
        up_wreq = 1'b0;
        up_rstn = 1'b0;
        #1;
        check("abort_wack", 32'(up_wack), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        check("abort_trig", 32'(trigger_req), 32'h0);
        check("abort_ctrl", {27'h0, ctrl_mode, ctrl_enable}, 32'h0);
        tick();
        up_rstn = 1'b1;
        tick();
        check("abort_wack_after", 32'(up_wack), 32'd0);
        tick();
        check("abort_wack_after2", 32'(up_wack), 32'd0);
        do_read("rd_scratch_abort", 14'h0002, 32'h0);
        do_read("rd_mask_abort", 14'h0012, 32'h0000_00FF);
        do_read("rd_pend_abort", 14'h0011, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
